adc_clip_detect: RTL and testbench
==================================

# adc_clip_detect

Detects ADC overload on the receive sample stream and drives the clip-indication flag consumed by the clip LED driver's `mode` input. Flags a clip event after a run of consecutive over-threshold (or ADC overrange) samples and holds the flag for a fixed time, so short overloads stay visible to the LED stage. It also keeps a saturating count of clip events for status readback.

## Interface
- `WIDTH`, 16: ADC sample width, two's complement.
- `THRESH`, 16'h7F00: magnitude threshold, positive, `WIDTH` bits.
- `RUN_LEN`, 3: number of consecutive over samples that constitute an event, range 1..255.
- `HOLD`, 32'd5_000_000: number of clock cycles `clip` stays high after the last event; must be ≥1.
- `clock`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `enable`  in  1  detector enable; 0 forces idle.
- `adc_data`  in  WIDTH  signed ADC sample.
- `adc_valid`  in  1  qualifies `adc_data` / `adc_ovr` this cycle.
- `adc_ovr`  in  1  ADC overrange pin, sampled with `adc_valid`.
- `clear`  in  1  synchronous clear of `clip_count`.
- `clip`  out  1  clip flag, registered; feeds LED driver `mode`.
- `clip_count`  out  16  saturating clip-event counter, registered.

## Operation
- **Over-sample:** a sample is over when `adc_valid`=1 and any of the following holds:
  - `adc_ovr`=1;
  - `adc_data` > +`THRESH`;
  - `adc_data` < −`THRESH`.
  - Comparison is signed, in `WIDTH`+1 bits so that the negation cannot overflow. The most negative code is over whenever `THRESH` < 2^(`WIDTH`−1).
- **Run counter** (8 bit):
  - Incremented by each over sample.
  - Reset to 0 by a valid non-over sample.
  - Unchanged in cycles with `adc_valid`=0.
  - An **event** fires when an over sample brings the run to `RUN_LEN`. The run counter then returns to 0 in the same update, so a retrigger needs another `RUN_LEN` over samples.
- **States:**
  - IDLE (`clip`=0): on event → CLIPPED, load timer = `HOLD`, increment `clip_count`.
  - CLIPPED (`clip`=1):
    - Timer decrements each cycle.
    - On event, reload timer = `HOLD` and stay in CLIPPED; `clip_count` is not incremented.
    - With no event and timer = 1 → IDLE.
- **`clip_count`:**
  - Increments once per IDLE→CLIPPED transition.
  - Saturates at 16'hFFFF.
  - `clear`=1 sets it to 0. Clear wins over a same-cycle increment.
- **`enable`=0:** state → IDLE, `clip`=0, run=0, timer=0 at the next edge. Events are ignored. `clip_count` is retained and `clear` still works.

## Timing
- **Reset** (`reset`=0 at an edge): `clip`=0, `clip_count`=0, run=0, timer=0, state IDLE. Reset overrides all other inputs.
- **Reset mid-hold:** `clip` drops after that edge, with no completion of the hold.
- **Latency:** the edge that samples the `RUN_LEN`-th over sample sets `clip`=1 (1-cycle latency from input to output register).
- **Hold length:** `clip` stays high exactly `HOLD` cycles after the last event edge, then goes low.
- **Event coinciding with timer = 1:** the reload wins; `clip` stays high, with no gap cycle.
- **`adc_valid` gaps:** gaps in the middle of a run do not break the run.
- **`clip_count` update:** in the same edge as the `clip` rise.
- **Event coinciding with `enable` falling:** `enable`=0 wins.
- **No handshake or backpressure:** samples are consumed every valid cycle.

## Test plan
Simulation parameters: `WIDTH`=16, `THRESH`=100, `RUN_LEN`=3, `HOLD`=10.

- **Reset values:** hold `reset`=0 for 2 cycles with random inputs → `clip`=0, `clip_count`=0; release, then feed samples of 50 → `clip` stays 0.
- **Basic event:**
  - Valid samples 101, −101, 200 on consecutive cycles → `clip`=1 after the third edge.
  - `clip_count`=1.
  - `clip` stays high for exactly 10 cycles, then returns to 0.
- **Run reset and thresholds:**
  - Samples 101, 101, 100, 101, 101 → no event, because 100 is not over.
  - Samples −32768, −101, with `adc_ovr`=1 on a sample of 0 → event.
  - Valid low for 4 cycles between over samples still yields an event on the third over sample.
- **Retrigger:**
  - A second run of 3 over samples while `clip`=1 and timer = 1 → `clip` stays high with no gap, held another 10 cycles.
  - `clip_count` stays 1.
- **Counter saturation and clear:**
  - Force 65 536 separate events → `clip_count`=16'hFFFF and holds.
  - `clear`=1 in the same cycle as a new event → `clip_count`=0 and `clip`=1.
- **Enable and reset mid-hold:**
  - `enable`=0 during hold → `clip`=0 next edge, `clip_count` unchanged.
  - Separately, `reset`=0 mid-hold → `clip`=0 and `clip_count`=0 next edge.

Source files
------------

// File: rtl/adc_clip_detect.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | adc_clip_detect: ADC overload detector with hold-stretched clip flag and  |
// | saturating clip-event counter.                             Revision: 1.0  |
// +--------------------------------------------------------------------------+
module adc_clip_detect #(
  parameter int               WIDTH   = 16,
  parameter logic [WIDTH-1:0] THRESH  = 16'h7F00,
  parameter int               RUN_LEN = 3,
  parameter logic [31:0]      HOLD    = 32'd5_000_000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  input  logic signed [WIDTH-1:0] adc_data,
  input  logic                    adc_valid,
  input  logic                    adc_ovr,
  input  logic                    clear,
  output logic                    clip,
  output logic [15:0]             clip_count
);

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_CLIPPED = 1'b1
  } state_t;

  localparam logic [7:0]  c_RUN_LEN = RUN_LEN[7:0];
  localparam logic [15:0] c_CNT_MAX = 16'hFFFF;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [31:0]        r_timer;
  logic [31:0]        w_timer_nxt;
  logic [7:0]         r_run;
  logic [7:0]         w_run_inc;
  logic [15:0]        r_count;
  logic               w_cnt_inc;
  logic               w_over;
  logic               w_event;
  logic signed [WIDTH:0] w_data_ext;
  logic signed [WIDTH:0] w_thr_pos;
  logic signed [WIDTH:0] w_thr_neg;

  // One extra bit keeps -THRESH and the most negative code representable.
  assign w_data_ext = {adc_data[WIDTH-1], adc_data};
  assign w_thr_pos  = {1'b0, THRESH};
  assign w_thr_neg  = -w_thr_pos;

  assign w_over    = adc_valid &&
                     (adc_ovr || (w_data_ext > w_thr_pos) || (w_data_ext < w_thr_neg));
  assign w_run_inc = r_run + 8'd1;
  assign w_event   = w_over && (w_run_inc == c_RUN_LEN);

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_run <= 8'd0;
    end else if (!enable) begin
      r_run <= 8'd0;
    end else if (adc_valid) begin
      r_run <= (w_over && !w_event) ? w_run_inc : 8'd0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_timer <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_cnt_inc   = 1'b0;
    if (!enable) begin
      w_state_nxt = S_IDLE;
      w_timer_nxt = 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_event) begin
            w_state_nxt = S_CLIPPED;
            w_timer_nxt = HOLD;
            w_cnt_inc   = 1'b1;
          end
        end
        S_CLIPPED: begin
          // A reload on the final hold cycle keeps the flag high without a gap.
          if (w_event) begin
            w_timer_nxt = HOLD;
          end else if (r_timer == 32'd1) begin
            w_state_nxt = S_IDLE;
            w_timer_nxt = 32'd0;
          end else begin
            w_timer_nxt = r_timer - 32'd1;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_timer_nxt = 32'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_count <= 16'd0;
    end else if (clear) begin
      r_count <= 16'd0;
    end else if (w_cnt_inc && (r_count != c_CNT_MAX)) begin
      r_count <= r_count + 16'd1;
    end
  end

  assign clip       = (r_state == S_CLIPPED);
  assign clip_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_adc_clip_detect.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_adc_clip_detect: directed self-checking bench for adc_clip_detect.     |
// |                                                            Revision: 1.0  |
// +--------------------------------------------------------------------------+
module tb_adc_clip_detect;

  logic               clock = 1'b0;
  logic               reset, enable, adc_valid, adc_ovr, clear;
  logic signed [15:0] adc_data;
  logic               clip;
  logic [15:0]        clip_count;

  // Second instance with RUN_LEN=1, HOLD=1 so 65536 events fit in 2 cycles each.
  logic               s_reset, s_enable, s_valid, s_ovr, s_clear;
  logic signed [15:0] s_data;
  logic               s_clip;
  logic [15:0]        s_count;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  adc_clip_detect #(
    .WIDTH(16), .THRESH(16'd100), .RUN_LEN(3), .HOLD(32'd10)
  ) u_dut (
    .clock(clock), .reset(reset), .enable(enable), .adc_data(adc_data),
    .adc_valid(adc_valid), .adc_ovr(adc_ovr), .clear(clear),
    .clip(clip), .clip_count(clip_count)
  );

  adc_clip_detect #(
    .WIDTH(16), .THRESH(16'd100), .RUN_LEN(1), .HOLD(32'd1)
  ) u_sat (
    .clock(clock), .reset(s_reset), .enable(s_enable), .adc_data(s_data),
    .adc_valid(s_valid), .adc_ovr(s_ovr), .clear(s_clear),
    .clip(s_clip), .clip_count(s_count)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sample(input logic signed [15:0] d, input logic ovr);
    adc_valid = 1'b1;
    adc_data  = d;
    adc_ovr   = ovr;
    tick();
    adc_valid = 1'b0;
    adc_ovr   = 1'b0;
  endtask

  initial begin
    reset = 1'b0; enable = 1'b1; adc_valid = 1'b0; adc_ovr = 1'b0; clear = 1'b0;
    adc_data = '0;
    s_reset = 1'b0; s_enable = 1'b0; s_valid = 1'b0; s_ovr = 1'b0; s_clear = 1'b0;
    s_data = '0;

    // Reset with random inputs
    for (int i = 0; i < 2; i++) begin
      adc_valid = 1'($urandom); adc_ovr = 1'($urandom); clear = 1'($urandom);
      enable = 1'($urandom); adc_data = 16'($urandom);
      tick();
    end
    check("rst_clip", 32'(clip), 32'd0);
    check("rst_count", 32'(clip_count), 32'd0);
    reset = 1'b1; enable = 1'b1; clear = 1'b0; adc_valid = 1'b0; adc_ovr = 1'b0;
    for (int i = 0; i < 5; i++) sample(16'sd50, 1'b0);
    check("below_thresh", 32'(clip), 32'd0);

    // Basic event and hold length
    sample(16'sd101, 1'b0);
    sample(-16'sd101, 1'b0);
    check("basic_pre", 32'(clip), 32'd0);
    sample(16'sd200, 1'b0);
    check("basic_clip", 32'(clip), 32'd1);
    check("basic_count", 32'(clip_count), 32'd1);
    for (int i = 1; i <= 9; i++) begin
      tick();
      check($sformatf("hold_%0d", i), 32'(clip), 32'd1);
    end
    tick();
    check("hold_end", 32'(clip), 32'd0);

    // Threshold equality breaks the run; run is left at 2 afterwards
    sample(16'sd101, 1'b0); sample(16'sd101, 1'b0); sample(16'sd100, 1'b0);
    sample(16'sd101, 1'b0); sample(16'sd101, 1'b0);
    check("thresh_eq", 32'(clip), 32'd0);
    sample(16'sd0, 1'b0);
    sample(-16'sd32768, 1'b0);
    sample(-16'sd101, 1'b0);
    check("neg_pre", 32'(clip), 32'd0);
    sample(16'sd0, 1'b1);
    check("ovr_clip", 32'(clip), 32'd1);
    check("ovr_count", 32'(clip_count), 32'd2);
    for (int i = 0; i < 10; i++) tick();
    check("ovr_hold_end", 32'(clip), 32'd0);

    // Valid gaps inside a run
    sample(16'sd101, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    sample(16'sd101, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    check("gap_pre", 32'(clip), 32'd0);
    sample(16'sd101, 1'b0);
    check("gap_clip", 32'(clip), 32'd1);
    check("gap_count", 32'(clip_count), 32'd3);

    // Retrigger landing exactly on the timer=1 cycle
    for (int i = 1; i <= 7; i++) begin
      tick();
      check($sformatf("rt_a%0d", i), 32'(clip), 32'd1);
    end
    sample(16'sd150, 1'b0);
    sample(16'sd150, 1'b0);
    check("rt_t1", 32'(clip), 32'd1);
    sample(16'sd150, 1'b0);
    check("rt_reload", 32'(clip), 32'd1);
    check("rt_count", 32'(clip_count), 32'd3);
    for (int i = 1; i <= 9; i++) begin
      tick();
      check($sformatf("rt_b%0d", i), 32'(clip), 32'd1);
    end
    tick();
    check("rt_end", 32'(clip), 32'd0);

    // Enable low mid-hold
    sample(16'sd300, 1'b0); sample(16'sd300, 1'b0); sample(16'sd300, 1'b0);
    check("en_clip", 32'(clip), 32'd1);
    tick(); tick();
    enable = 1'b0;
    tick();
    check("en_drop", 32'(clip), 32'd0);
    check("en_count", 32'(clip_count), 32'd4);

    // Event coinciding with enable falling; enable low also clears the run
    enable = 1'b1;
    sample(16'sd300, 1'b0); sample(16'sd300, 1'b0);
    enable = 1'b0;
    sample(16'sd300, 1'b0);
    check("en_evt_clip", 32'(clip), 32'd0);
    check("en_evt_count", 32'(clip_count), 32'd4);
    enable = 1'b1;
    sample(16'sd300, 1'b0);
    check("en_run_clr", 32'(clip), 32'd0);
    sample(16'sd0, 1'b0);

    // Reset mid-hold
    sample(16'sd300, 1'b0); sample(16'sd300, 1'b0); sample(16'sd300, 1'b0);
    check("rmh_clip", 32'(clip), 32'd1);
    check("rmh_count", 32'(clip_count), 32'd5);
    tick(); tick();
    reset = 1'b0;
    tick();
    check("rmh_drop", 32'(clip), 32'd0);
    check("rmh_count0", 32'(clip_count), 32'd0);
    reset = 1'b1;

    // Saturation on the fast instance
    tick();
    s_reset = 1'b1; s_enable = 1'b1; s_data = 16'sd200;
    for (int i = 0; i < 65536; i++) begin
      s_valid = 1'b1;
      tick();
      if (i == 999) check("sat_1000", 32'(s_count), 32'd1000);
      s_valid = 1'b0;
      tick();
    end
    check("sat_full", 32'(s_count), 32'hFFFF);
    check("sat_idle", 32'(s_clip), 32'd0);
    s_valid = 1'b1;
    tick();
    check("sat_clip", 32'(s_clip), 32'd1);
    check("sat_hold", 32'(s_count), 32'hFFFF);
    s_valid = 1'b0;
    tick();
    s_valid = 1'b1; s_clear = 1'b1;
    tick();
    check("clr_clip", 32'(s_clip), 32'd1);
    check("clr_count", 32'(s_count), 32'd0);
    s_valid = 1'b0; s_clear = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
